// File: rtl/rc4_prga_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : rc4_prga_if
//  Purpose  : Bundles the start/ready handshake of the RC4 PRGA stage together
//             with its three memory ports (S memory, ciphertext ROM and
//             plaintext RAM).
//  Modports : master - the PRGA core; drives addresses, write data, write
//                      enables, rdy and bad_char; receives en and read data.
//             slave  - the surrounding top level and memories.
//  Signals  : en, rdy, s_addr/s_rddata/s_wrdata/s_wren,
//             ct_addr/ct_rddata, pt_addr/pt_wrdata/pt_wren, bad_char
//  Revision : 1.0 - initial release
// ============================================================================
interface rc4_prga_if #(
    parameter int MSG_AW = 8
);
    logic              en;
    logic              rdy;
    logic [7:0]        s_addr;
    logic [7:0]        s_rddata;
    logic [7:0]        s_wrdata;
    logic              s_wren;
    logic [MSG_AW-1:0] ct_addr;
    logic [7:0]        ct_rddata;
    logic [MSG_AW-1:0] pt_addr;
    logic [7:0]        pt_wrdata;
    logic              pt_wren;
    logic              bad_char;

    modport master (
        input  en, s_rddata, ct_rddata,
        output rdy, s_addr, s_wrdata, s_wren, ct_addr,
               pt_addr, pt_wrdata, pt_wren, bad_char
    );

    modport slave (
        output en, s_rddata, ct_rddata,
        input  rdy, s_addr, s_wrdata, s_wren, ct_addr,
               pt_addr, pt_wrdata, pt_wren, bad_char
    );
endinterface
`default_nettype wire

// File: rtl/rc4_prga.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : rc4_prga
//  Purpose  : RC4 pseudo-random generation stage. Reads a length-prefixed
//             ciphertext from CT ROM, runs the RC4 PRGA over the S memory left
//             by the key schedule, and writes the length-prefixed plaintext
//             (ct ^ keystream) to PT RAM. Nine cycles per byte.
//  Ports    : clk   - system clock
//             rst_n - synchronous active-low reset
//             bus   - rc4_prga_if.master (en/rdy handshake, S, CT, PT ports)
//  Options  : PRGA_ASCII_CHECK_EN - when defined, the run stops after the
//             first plaintext byte outside 0x20..0x7E and bad_char is raised
//             until the next accepted start. Undefined: bad_char is tied 0.
//  Revision : 1.0 - initial release
// ============================================================================
module rc4_prga #(
    parameter int MSG_AW = 8
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    rc4_prga_if.master  bus
);

    // One state per cycle. Every output is registered: the actions listed for
    // a state are loaded on the edge that enters it.
    localparam logic [3:0] c_ST_IDLE     = 4'd0;
    localparam logic [3:0] c_ST_RD_LEN   = 4'd1;
    localparam logic [3:0] c_ST_WAIT_LEN = 4'd2;
    localparam logic [3:0] c_ST_WR_LEN   = 4'd3;
    localparam logic [3:0] c_ST_RD_SI    = 4'd4;
    localparam logic [3:0] c_ST_WAIT_SI  = 4'd5;
    localparam logic [3:0] c_ST_RD_SJ    = 4'd6;
    localparam logic [3:0] c_ST_WAIT_SJ  = 4'd7;
    localparam logic [3:0] c_ST_SW_I     = 4'd8;
    localparam logic [3:0] c_ST_SW_J     = 4'd9;
    localparam logic [3:0] c_ST_RD_PAD   = 4'd10;
    localparam logic [3:0] c_ST_WAIT_PAD = 4'd11;
    localparam logic [3:0] c_ST_WR_PT    = 4'd12;
    localparam logic [3:0] c_ST_DONE     = 4'd13;

    localparam logic [MSG_AW-1:0] c_K_ONE = MSG_AW'(1);

    logic [3:0]        r_state;
    logic [7:0]        r_i;
    logic [7:0]        r_j;
    logic [7:0]        r_si;
    logic [7:0]        r_sj;
    logic [7:0]        r_c;
    logic [MSG_AW-1:0] r_k;
    logic [MSG_AW-1:0] r_len;
    logic              r_rdy;
    logic [7:0]        r_s_addr;
    logic [7:0]        r_s_wrdata;
    logic              r_s_wren;
    logic [MSG_AW-1:0] r_ct_addr;
    logic [MSG_AW-1:0] r_pt_addr;
    logic [7:0]        r_pt_wrdata;
    logic              r_pt_wren;

    logic [7:0]        w_i_next;
    logic [MSG_AW-1:0] w_k_next;
    logic              w_stop_early;

    assign w_i_next = r_i + 8'd1;
    assign w_k_next = r_k + c_K_ONE;

`ifdef PRGA_ASCII_CHECK_EN
    logic r_bad_char;
    // The byte just written in WR_PT is still held in r_pt_wrdata.
    assign w_stop_early = (r_pt_wrdata < 8'h20) || (r_pt_wrdata > 8'h7E);
    assign bus.bad_char = r_bad_char;
`else
    assign w_stop_early = 1'b0;
    assign bus.bad_char = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_i         <= '0;
            r_j         <= '0;
            r_si        <= '0;
            r_sj        <= '0;
            r_c         <= '0;
            r_k         <= '0;
            r_len       <= '0;
            r_rdy       <= 1'b1;
            r_s_addr    <= '0;
            r_s_wrdata  <= '0;
            r_s_wren    <= 1'b0;
            r_ct_addr   <= '0;
            r_pt_addr   <= '0;
            r_pt_wrdata <= '0;
            r_pt_wren   <= 1'b0;
`ifdef PRGA_ASCII_CHECK_EN
            r_bad_char  <= 1'b0;
`endif
        end else begin
            // Write enables are single-cycle pulses unless a state re-arms them.
            r_s_wren  <= 1'b0;
            r_pt_wren <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.en) begin
                        r_rdy     <= 1'b0;
                        r_i       <= '0;
                        r_j       <= '0;
                        r_k       <= '0;
                        r_ct_addr <= '0;
`ifdef PRGA_ASCII_CHECK_EN
                        r_bad_char <= 1'b0;
`endif
                        r_state   <= c_ST_RD_LEN;
                    end
                end
                c_ST_RD_LEN: r_state <= c_ST_WAIT_LEN;
                c_ST_WAIT_LEN: begin
                    r_len       <= MSG_AW'(bus.ct_rddata);
                    r_pt_addr   <= '0;
                    r_pt_wrdata <= bus.ct_rddata;
                    r_pt_wren   <= 1'b1;
                    r_state     <= c_ST_WR_LEN;
                end
                c_ST_WR_LEN: begin
                    if (r_len == '0) begin
                        r_state <= c_ST_DONE;
                    end else begin
                        r_k       <= c_K_ONE;
                        r_i       <= w_i_next;
                        r_s_addr  <= w_i_next;
                        r_ct_addr <= c_K_ONE;
                        r_state   <= c_ST_RD_SI;
                    end
                end
                c_ST_RD_SI: r_state <= c_ST_WAIT_SI;
                c_ST_WAIT_SI: begin
                    r_si     <= bus.s_rddata;
                    r_c      <= bus.ct_rddata;
                    r_j      <= r_j + bus.s_rddata;
                    r_s_addr <= r_j + bus.s_rddata;
                    r_state  <= c_ST_RD_SJ;
                end
                c_ST_RD_SJ: r_state <= c_ST_WAIT_SJ;
                c_ST_WAIT_SJ: begin
                    r_sj       <= bus.s_rddata;
                    r_s_addr   <= r_i;
                    r_s_wrdata <= bus.s_rddata;
                    r_s_wren   <= 1'b1;
                    r_state    <= c_ST_SW_I;
                end
                c_ST_SW_I: begin
                    // When i == j this rewrites the same cell with si, which is
                    // also sj, so the cell ends with its original value.
                    r_s_addr   <= r_j;
                    r_s_wrdata <= r_si;
                    r_s_wren   <= 1'b1;
                    r_state    <= c_ST_SW_J;
                end
                c_ST_SW_J: begin
                    r_s_addr <= r_si + r_sj;
                    r_state  <= c_ST_RD_PAD;
                end
                c_ST_RD_PAD: r_state <= c_ST_WAIT_PAD;
                c_ST_WAIT_PAD: begin
                    r_pt_addr   <= r_k;
                    r_pt_wrdata <= bus.s_rddata ^ r_c;
                    r_pt_wren   <= 1'b1;
                    r_state     <= c_ST_WR_PT;
                end
                c_ST_WR_PT: begin
                    if (r_k == r_len || w_stop_early) begin
`ifdef PRGA_ASCII_CHECK_EN
                        r_bad_char <= w_stop_early;
`endif
                        r_state <= c_ST_DONE;
                    end else begin
                        r_k       <= w_k_next;
                        r_i       <= w_i_next;
                        r_s_addr  <= w_i_next;
                        r_ct_addr <= w_k_next;
                        r_state   <= c_ST_RD_SI;
                    end
                end
                c_ST_DONE: begin
                    r_rdy   <= 1'b1;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_rdy   <= 1'b1;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rdy       = r_rdy;
    assign bus.s_addr    = r_s_addr;
    assign bus.s_wrdata  = r_s_wrdata;
    assign bus.s_wren    = r_s_wren;
    assign bus.ct_addr   = r_ct_addr;
    assign bus.pt_addr   = r_pt_addr;
    assign bus.pt_wrdata = r_pt_wrdata;
    assign bus.pt_wren   = r_pt_wren;

endmodule
`default_nettype wire

// File: tb/tb_rc4_prga.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_rc4_prga
//  Purpose  : Self-checking bench for rc4_prga. Hand-computed vectors on an
//             identity S, multi-cycle corner sequences (held en, toggled en,
//             mid-run reset) and random permutations checked against a plain
//             RC4 PRGA reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rc4_prga;
    localparam int MSG_AW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rc4_prga_if #(.MSG_AW(MSG_AW)) bus();
    rc4_prga #(.MSG_AW(MSG_AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed { logic [7:0] addr; logic [7:0] data; } wr_t;

    logic [7:0] s_mem [256];
    logic [7:0] ct_mem[256];
    logic [7:0] s_init[256];
    logic [7:0] ct_init[256];
    logic [7:0] m_s   [256];
    logic       load_req = 1'b0;
    wr_t        pt_log[$];
    logic [7:0] exp_pt[$];
    bit         exp_bad;

    int n_checks = 0;
    int n_pass   = 0;

    // Memories: single port, one-cycle read latency.
    always @(posedge clk) begin
        if (load_req) begin
            for (int a = 0; a < 256; a++) begin
                s_mem[a]  <= s_init[a];
                ct_mem[a] <= ct_init[a];
            end
            pt_log.delete();
        end else begin
            bus.s_rddata  <= s_mem[bus.s_addr];
            bus.ct_rddata <= ct_mem[bus.ct_addr];
            if (bus.s_wren) s_mem[bus.s_addr] <= bus.s_wrdata;
            if (bus.pt_wren) pt_log.push_back('{addr: bus.pt_addr, data: bus.pt_wrdata});
        end
    end

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    endtask

    task automatic load_mems();
        for (int a = 0; a < 256; a++) m_s[a] = s_init[a];
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic set_identity();
        for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
    endtask

    // Reference RC4 PRGA on m_s; appends the expected pt writes to exp_pt.
    task automatic model_run();
        logic [7:0] i, j, t, p, len;
        i = 8'd0; j = 8'd0; len = ct_init[0];
        exp_bad = 1'b0;
        exp_pt.push_back(len);
        for (int k = 1; k <= int'(len); k++) begin
            i = i + 8'd1;
            j = j + m_s[i];
            t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
            p = ct_init[k] ^ m_s[8'(m_s[i] + m_s[j])];
            exp_pt.push_back(p);
`ifdef PRGA_ASCII_CHECK_EN
            if (p < 8'h20 || p > 8'h7E) begin
                exp_bad = 1'b1;
                break;
            end
`endif
        end
    endtask

    // Starts one run and counts cycles after the accept edge until rdy=1.
    task automatic run_once(input bit toggle_en, output int cycles);
        @(negedge clk);
        chk("rdy_before_start", int'(bus.rdy), 1);
        bus.en = 1'b1;
        @(posedge clk);
        #1 bus.en = 1'b0;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) begin
                chk("rdy_drop", int'(bus.rdy), 0);
                chk("bad_char_clear_on_start", int'(bus.bad_char), 0);
            end
            if (toggle_en) bus.en = bus.rdy ? 1'b0 : 1'($urandom_range(0, 1));
        end while (!bus.rdy && cycles < 4000);
        bus.en = 1'b0;
        if (cycles >= 4000) chk("rdy_timeout", 1, 0);
    endtask

    task automatic compare_log(input string tag, input int run_len);
        int mism;
        chk({tag, "_pt_count"}, pt_log.size(), exp_pt.size());
        for (int x = 0; x < pt_log.size() && x < exp_pt.size(); x++) begin
            chk({tag, "_pt_addr"}, int'(pt_log[x].addr), x % run_len);
            chk({tag, "_pt_data"}, int'(pt_log[x].data), int'(exp_pt[x]));
        end
        mism = 0;
        for (int a = 0; a < 256; a++) if (s_mem[a] !== m_s[a]) mism++;
        chk({tag, "_s_final_mismatches"}, mism, 0);
    endtask

    typedef struct {
        logic [7:0] ct[4];
        logic [7:0] pt[4];
        int         n_pt;
        int         cyc;
        bit         bad;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int cycles;
        int n1;

        bus.en = 1'b0;
        bus.s_rddata = 8'h00;
        bus.ct_rddata = 8'h00;

        tbl[0] = '{ct: '{8'h03, 8'h4A, 8'h6C, 8'h26}, pt: '{8'h03, 8'h48, 8'h69, 8'h21}, n_pt: 4, cyc: 32, bad: 1'b0};
        tbl[1] = '{ct: '{8'h00, 8'h00, 8'h00, 8'h00}, pt: '{8'h00, 8'h00, 8'h00, 8'h00}, n_pt: 1, cyc: 5,  bad: 1'b0};
        tbl[3] = '{ct: '{8'h02, 8'h4A, 8'h6C, 8'h00}, pt: '{8'h02, 8'h48, 8'h69, 8'h00}, n_pt: 3, cyc: 23, bad: 1'b0};
`ifdef PRGA_ASCII_CHECK_EN
        tbl[2] = '{ct: '{8'h01, 8'h00, 8'h00, 8'h00}, pt: '{8'h01, 8'h02, 8'h00, 8'h00}, n_pt: 2, cyc: 14, bad: 1'b1};
        tbl[4] = '{ct: '{8'h03, 8'h4A, 8'h00, 8'h26}, pt: '{8'h03, 8'h48, 8'h05, 8'h00}, n_pt: 3, cyc: 23, bad: 1'b1};
`else
        tbl[2] = '{ct: '{8'h01, 8'h00, 8'h00, 8'h00}, pt: '{8'h01, 8'h02, 8'h00, 8'h00}, n_pt: 2, cyc: 14, bad: 1'b0};
        tbl[4] = '{ct: '{8'h03, 8'h4A, 8'h00, 8'h26}, pt: '{8'h03, 8'h48, 8'h05, 8'h21}, n_pt: 4, cyc: 32, bad: 1'b0};
`endif

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_rdy", int'(bus.rdy), 1);
        chk("reset_s_wren", int'(bus.s_wren), 0);
        chk("reset_pt_wren", int'(bus.pt_wren), 0);
        chk("reset_s_addr", int'(bus.s_addr), 0);
        chk("reset_s_wrdata", int'(bus.s_wrdata), 0);
        chk("reset_ct_addr", int'(bus.ct_addr), 0);
        chk("reset_pt_addr", int'(bus.pt_addr), 0);
        chk("reset_pt_wrdata", int'(bus.pt_wrdata), 0);
        chk("reset_bad_char", int'(bus.bad_char), 0);
        rst_n = 1'b1;

        // Table-driven vectors on identity S
        for (int v = 0; v < 5; v++) begin
            int mism;
            set_identity();
            for (int a = 0; a < 256; a++) ct_init[a] = 8'h00;
            for (int b = 0; b < 4; b++) ct_init[b] = tbl[v].ct[b];
            load_mems();
            run_once(1'b0, cycles);
            chk("tbl_cycles", cycles, tbl[v].cyc);
            chk("tbl_bad_char", int'(bus.bad_char), int'(tbl[v].bad));
            chk("tbl_pt_count", pt_log.size(), tbl[v].n_pt);
            for (int x = 0; x < pt_log.size() && x < tbl[v].n_pt; x++) begin
                chk("tbl_pt_addr", int'(pt_log[x].addr), x);
                chk("tbl_pt_data", int'(pt_log[x].data), int'(tbl[v].pt[x]));
            end
            if (tbl[v].n_pt == 1) begin
                mism = 0;
                for (int a = 0; a < 256; a++) if (s_mem[a] !== 8'(a)) mism++;
                chk("len0_s_unchanged_mismatches", mism, 0);
            end
        end

        // en held high: the run restarts with the same CT on the updated S
        set_identity();
        for (int a = 0; a < 256; a++) ct_init[a] = 8'h00;
        for (int b = 0; b < 4; b++) ct_init[b] = tbl[0].ct[b];
        load_mems();
        exp_pt.delete();
        model_run();
        n1 = exp_pt.size();
        model_run();
        @(negedge clk);
        bus.en = 1'b1;
        @(posedge clk);
        #1;
        cycles = 0;
        do begin @(negedge clk); cycles++; end while (!bus.rdy && cycles < 4000);
        chk("hold_first_cycles", cycles, 32);
        @(posedge clk);
        #1 bus.en = 1'b0;
        cycles = 0;
        do begin @(negedge clk); cycles++; end while (!bus.rdy && cycles < 4000);
        chk("hold_second_cycles", cycles, 32);
        compare_log("hold", n1);

        // en toggled while busy has no effect
        set_identity();
        load_mems();
        exp_pt.delete();
        model_run();
        run_once(1'b1, cycles);
        chk("toggle_cycles", cycles, 32);
        compare_log("toggle", exp_pt.size());

        // Reset during the second byte's SW_I
        set_identity();
        load_mems();
        @(negedge clk);
        bus.en = 1'b1;
        @(posedge clk);
        #1 bus.en = 1'b0;
        repeat (17) @(negedge clk);
        chk("swi_s_wren", int'(bus.s_wren), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_rdy", int'(bus.rdy), 1);
        chk("abort_s_wren", int'(bus.s_wren), 0);
        chk("abort_pt_wren", int'(bus.pt_wren), 0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_pt_writes", pt_log.size(), 2);
        chk("abort_rdy_stays", int'(bus.rdy), 1);

        set_identity();
        load_mems();
        exp_pt.delete();
        model_run();
        run_once(1'b0, cycles);
        chk("rerun_cycles", cycles, 32);
        compare_log("rerun", exp_pt.size());
        chk("rerun_s1", int'(s_mem[1]), 8'h01);
        chk("rerun_s2", int'(s_mem[2]), 8'h03);
        chk("rerun_s3", int'(s_mem[3]), 8'h05);
        chk("rerun_s5", int'(s_mem[5]), 8'h02);

        // Random permutations and messages against the reference model
        for (int r = 0; r < 7; r++) begin
            int len;
            set_identity();
            for (int a = 255; a > 0; a--) begin
                int b;
                logic [7:0] t;
                b = $urandom_range(0, a);
                t = s_init[a]; s_init[a] = s_init[b]; s_init[b] = t;
            end
            len = (r == 6) ? 255 : $urandom_range(1, 30);
            for (int a = 0; a < 256; a++) ct_init[a] = 8'($urandom_range(0, 255));
            ct_init[0] = 8'(len);
            load_mems();
            exp_pt.delete();
            model_run();
            run_once(1'($urandom_range(0, 1)), cycles);
            chk("rand_cycles", cycles, 5 + 9 * (exp_pt.size() - 1));
            chk("rand_bad_char", int'(bus.bad_char), int'(exp_bad));
            compare_log("rand", exp_pt.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/rc4_prga.md
Name: rc4_prga

Overview:
- RC4 pseudo-random generation stage; sits directly downstream of the key-scheduling (KSA) stage.
- Consumes the permuted S memory that the KSA leaves behind.
- Reads a length-prefixed ciphertext from CT ROM, XORs each byte with the keystream and writes a length-prefixed plaintext to PT RAM.
- The top level starts it once the KSA reports done. It shares the S-memory port with the KSA through a top-level mux.

Parameters:
- MSG_AW, 8, address width of CT/PT memories; maximum message length is 2^MSG_AW-1 bytes.

Ports:
- clk  in  1  system clock (CLOCK_50 at top)
- rst_n  in  1  synchronous active-low reset (KEY[3] at top)
- en  in  1  start request; sampled only while rdy=1
- rdy  out  1  idle/ready indicator
- s_addr  out  8  S memory address
- s_rddata  in  8  S memory read data
- s_wrdata  out  8  S memory write data
- s_wren  out  1  S memory write enable
- ct_addr  out  MSG_AW  ciphertext ROM address
- ct_rddata  in  8  ciphertext ROM read data
- pt_addr  out  MSG_AW  plaintext RAM address
- pt_wrdata  out  8  plaintext RAM write data
- pt_wren  out  1  plaintext RAM write enable
- bad_char  out  1  non-printable flag; see Optional Feature

Behaviour:
- Reset and clocking:
  - One clock. Reset is synchronous and active-low.
  - Reset outputs: rdy=1, every wren=0, all addresses/data=0, bad_char=0. Internal i, j, k, L = 0. State = IDLE.
  - Reset mid-operation aborts at once with no further writes. Partially written memories are left as-is.
- Memories:
  - Single-port, 1-cycle read latency.
  - The FSM holds each read address for 2 cycles (issue + WAIT) and samples read data in the following state.
- Handshake:
  - en is accepted on a cycle with rdy=1 and en=1; rdy drops on the next cycle.
  - en is ignored while rdy=0.
  - If en is still high when rdy returns to 1, a new run starts. Each run restarts with i=j=0 and uses the current S contents.
- FSM, one state per cycle:
  - IDLE: rdy=1.
  - RD_LEN: ct_addr=0.
  - WAIT_LEN.
  - WR_LEN: L=ct_rddata; pt[0]=L. If L=0, go to DONE; else k=1.
  - RD_SI: i=i+1 (mod 256); s_addr=i; ct_addr=k.
  - WAIT_SI.
  - RD_SJ: capture si=s_rddata and ct byte c; j=j+si (mod 256); s_addr=j.
  - WAIT_SJ.
  - SW_I: capture sj; write S[i]=sj.
  - SW_J: write S[j]=si.
  - RD_PAD: s_addr=(si+sj) mod 256.
  - WAIT_PAD.
  - WR_PT: pt[k]=s_rddata^c. If k==L, go to DONE; else k=k+1 and go to RD_SI.
  - DONE: go to IDLE.
- Timing:
  - 9 cycles per byte.
  - rdy reasserts exactly 5+9*L cycles after the en-accept edge.
- Arithmetic and wrap:
  - All S-index arithmetic is 8-bit wrap-around.
  - When i=j, both swap writes hit the same address; the final value equals the original.
  - L=255 is supported; k never wraps.

Optional Feature:
- Macro: PRGA_ASCII_CHECK_EN
- Defined:
  - In WR_PT, a plaintext byte outside 0x20..0x7E is still written, then the FSM goes to DONE.
  - bad_char=1 from that DONE cycle until the next en accept, which clears it.
  - Gives early rejection for key search.
- Undefined: bad_char tied 0; all bytes are always processed.

Test Plan:
- Identity S (S[x]=x), CT={03,4A,6C,26}, pulse en -> PT={03,48,69,21} ("Hi!"). S[1]=01, S[2]=03, S[3]=05, S[5]=02. rdy high exactly 32 cycles after the accept edge.
- CT={00} -> exactly one pt write (addr 0, data 00); S unchanged; rdy back after 5 cycles.
- Reset asserted during the 2nd byte's SW_I -> next cycle rdy=1 and all wren=0. pt[2] is never written. A fresh en with restored identity S reproduces test 1.
- en held high continuously through test 1 -> run restarts once rdy=1 (same CT, current S). en toggled while busy -> no effect on write sequence or timing.
- With PRGA_ASCII_CHECK_EN, identity S, CT={03,4A,00,26} -> pt[1]=48, pt[2]=05, bad_char=1, pt[3] never written. Without the macro -> pt[3]=21, bad_char=0.
